// File: rtl/irq_arbiter_pkg.sv
// Shared types and helpers for the irq_arbiter slice: state encoding,
// requester count and the reset value of the round-robin pointer.
package irq_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int num_req(input int cw);
    return 1 << cw;
  endfunction

  // The pointer starts at the top index, so the first search begins at 0.
  function automatic int last_reset(input int cw);
    return num_req(cw) - 1;
  endfunction

endpackage

// File: rtl/mux.sv
// Shared datapath multiplexer: selects block b(s) out of {b(0), ..., b(N-1)},
// where b(0) sits in the most significant bits of i.
module mux #(
  parameter int DW = 1,
  parameter int CW = 2,
  localparam int N = 1 << CW
) (
  input  logic [DW*N-1:0] i,
  input  logic [CW-1:0]   s,
  output logic [DW-1:0]   o
);

  always_comb begin
    o = '0;
    for (int k = 0; k < N; k++) begin
      if (s == CW'(k)) o = i[(N-1-k)*DW +: DW];
    end
  end

endmodule

// File: rtl/prio_enc.sv
// Rotating priority encoder: returns the first set request at or after
// index start (modulo N), plus whether any request is set at all.
module prio_enc
  import irq_arbiter_pkg::*;
#(
  parameter int CW = 2,
  localparam int N = num_req(CW)
) (
  input  logic [N-1:0]  req,
  input  logic [CW-1:0] start,
  output logic [CW-1:0] idx,
  output logic          any
);

  // Scan from the far end back toward start so the closest hit is written last.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    idx = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[start + CW'(k)]) idx = start + CW'(k);
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Request arbiter sharing one mux between N requesters; the grant is held until ack.
// Define IRQ_ARBITER_RR_EN for round-robin selection, otherwise fixed priority (lowest index wins).
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int DW = 1,
  parameter int CW = 2,
  localparam int N = num_req(CW)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [DW*N-1:0] i,
  input  logic            ack,
  output logic [DW-1:0]   o,
  output logic            valid,
  output logic [CW-1:0]   sel,
  output logic [N-1:0]    grant
);

  state_t        state, state_nxt;
  logic [CW-1:0] start;
  logic [CW-1:0] win;
  logic          any;

`ifdef IRQ_ARBITER_RR_EN
  localparam logic [CW-1:0] LAST_RST = CW'(last_reset(CW));
  logic [CW-1:0] last;

  assign start = last + CW'(1);
`else
  assign start = '0;
`endif

  prio_enc #(.CW(CW)) u_prio_enc (
    .req   (req),
    .start (start),
    .idx   (win),
    .any   (any)
  );

  mux #(.DW(DW), .CW(CW)) u_mux (
    .i (i),
    .s (sel),
    .o (o)
  );

  always_ff @(posedge clk) begin
    // NOTE: registers are always written with <= so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    valid     = 1'b0;
    grant     = '0;
    case (state)
      IDLE: if (any) state_nxt = BUSY;
      BUSY: begin
        valid      = 1'b1;
        grant[sel] = 1'b1;
        if (ack) state_nxt = IDLE;
      end
    endcase
  end

  // sel moves only when a grant is issued; it is held through BUSY and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel  <= '0;
`ifdef IRQ_ARBITER_RR_EN
      last <= LAST_RST;
`endif
    end else begin
      if (state == IDLE && any) sel <= win;
`ifdef IRQ_ARBITER_RR_EN
      if (state == BUSY && ack) last <= sel;
`endif
    end
  end

endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter (DW=8, CW=2): directed scenarios followed by
// random traffic, all compared against a behavioural model of the grant rules.
module tb_irq_arbiter;

  localparam int DW = 8;
  localparam int CW = 2;
  localparam int N  = 4;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [DW*N-1:0] i;
  logic            ack;
  logic [DW-1:0]   o;
  logic            valid;
  logic [CW-1:0]   sel;
  logic [N-1:0]    grant;

  logic [DW-1:0] dat [N];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_busy;
  int m_sel;
  int m_last;

  irq_arbiter #(.DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .i     (i),
    .ack   (ack),
    .o     (o),
    .valid (valid),
    .sel   (sel),
    .grant (grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_i();
    i = {dat[0], dat[1], dat[2], dat[3]};
  endtask

  function automatic int pick(input logic [N-1:0] r);
`ifdef IRQ_ARBITER_RR_EN
    for (int d = 1; d <= N; d++) begin
      int k;
      k = (m_last + d) % N;
      if (r[k]) return k;
    end
`else
    for (int k = 0; k < N; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  function automatic void model_edge();
    int w;
    if (rst) begin
      m_busy = 1'b0;
      m_sel  = 0;
      m_last = N - 1;
    end else if (m_busy) begin
      if (ack) begin
        m_busy = 1'b0;
        m_last = m_sel;
      end
    end else begin
      w = pick(req);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_sel  = w;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    logic [N-1:0] g;
    g = m_busy ? N'(1 << m_sel) : '0;
    check({tag, "_valid"}, valid, m_busy);
    check({tag, "_sel"},   sel,   m_sel);
    check({tag, "_grant"}, grant, g);
    check({tag, "_o"},     o,     dat[m_sel]);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  int exp_s3 [5];
  int exp_s4 [2];
  int g;

  initial begin
    dat[0] = 8'hA0; dat[1] = 8'hA1; dat[2] = 8'hA2; dat[3] = 8'hA3;
    drive_i();
    rst = 1'b1; req = 4'b1111; ack = 1'b0;
    m_busy = 1'b0; m_sel = 0; m_last = N - 1;
`ifdef IRQ_ARBITER_RR_EN
    exp_s3 = '{0, 1, 2, 3, 0};
    exp_s4 = '{1, 3};
`else
    exp_s3 = '{0, 0, 0, 0, 0};
    exp_s4 = '{1, 1};
`endif

    // 1: reset held two cycles with all requests pending
    step("s1_rst0");
    step("s1_rst1");
    rst = 1'b0;
    step("s1_rel");
    check("s1_first_valid", valid, 1'b1);
    check("s1_first_sel", sel, 0);
    check("s1_first_o", o, 8'hA0);
    ack = 1'b1; req = '0;
    step("s1_ack");
    ack = 1'b0;

    // 2: single request, held grant, ack release
    req = 4'b0100;
    step("s2_grant");
    check("s2_sel", sel, 2);
    check("s2_grant", grant, 4'b0100);
    check("s2_o", o, 8'hA2);
    req = '0;
    for (int n = 0; n < 5; n++) step("s2_hold");
    check("s2_still_held", grant, 4'b0100);
    ack = 1'b1;
    step("s2_release");
    check("s2_released", valid, 1'b0);
    ack = 1'b0;

    // 3: all requesting, ack held high; fresh reset so the search starts at 0
    rst = 1'b1;
    step("s3_rst");
    rst = 1'b0; req = 4'b1111; ack = 1'b1;
    g = 0;
    for (int n = 0; n < 10; n++) begin
      step("s3");
      check("s3_alternate", valid, (n % 2 == 0));
      if (valid === 1'b1 && g < 5) begin
        check("s3_seq", sel, exp_s3[g]);
        g++;
      end
    end
    check("s3_grant_count", g, 5);

    // 4: requesters 1 and 3 only
    req = 4'b1010;
    g = 0;
    for (int n = 0; n < 4; n++) begin
      step("s4");
      if (valid === 1'b1 && g < 2) begin
        check("s4_seq", sel, exp_s4[g]);
        g++;
      end
    end
    check("s4_grant_count", g, 2);

    // 5: new request in the same cycle as ack, then ack while idle
    ack = 1'b0; req = 4'b0010;
    step("s5_grant1");
    check("s5_sel1", sel, 1);
    req = 4'b1000; ack = 1'b1;
    step("s5_idle");
    check("s5_idle_gap", valid, 1'b0);
    ack = 1'b0;
    step("s5_grant3");
    check("s5_sel3", sel, 3);
    ack = 1'b1; req = '0;
    step("s5_rel");
    step("s5_idle_ack");
    check("s5_idle_ack_valid", valid, 1'b0);
    check("s5_idle_ack_sel", sel, 3);
    ack = 1'b0;

    // 6: combinational data path, then reset while busy
    req = 4'b0100;
    step("s6_grant");
    dat[2] = 8'h5C; drive_i();
    #1;
    check("s6_comb_o", o, 8'h5C);
    dat[2] = 8'hA2; drive_i();
    rst = 1'b1; req = '0;
    step("s6_rst");
    check("s6_rst_valid", valid, 1'b0);
    check("s6_rst_grant", grant, 4'b0000);
    rst = 1'b0; req = 4'b0100;
    step("s6_regrant");
    check("s6_regrant_sel", sel, 2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req = 4'($urandom);
      ack = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) begin
        dat[$urandom_range(0, N - 1)] = 8'($urandom);
        drive_i();
      end
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/irq_arbiter.md
# irq_arbiter

Sequential arbiter that shares one `mux` datapath among 2**CW interrupt/data requesters. It picks one pending requester, drives the `mux` select with that requester's index, and holds the grant until the consumer acknowledges. It sits between the requester bank and the single consumer port, for example the CPU-side interrupt vector/data register.

## Interface

Parameters:
- DW, 1: width of each requester's data block and of output `o`.
- CW, 2: select width; N = 2**CW requesters.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N  request lines; `req[k]` = requester k pending (level).
- i  in  DW*N  requester data, packed as {b(0), b(1), ..., b(N-1)}; b(0) occupies the MSBs.
- ack  in  1  consumer acknowledges the current grant.
- o  out  DW  data of the granted requester, b(sel).
- valid  out  1  a grant is active; `o` is meaningful.
- sel  out  CW  index of the granted requester.
- grant  out  N  one-hot grant; `grant[sel]` = valid.

## Operation

The arbiter has two states.

**IDLE** (reset state):
- `valid` = 0 and `grant` = 0.
- If any `req[k]`=1, register the winner index into `sel` and go to BUSY.
- If `req` = 0, stay in IDLE.

**BUSY**:
- `valid` = 1 and `grant` = one-hot(sel); `o` = b(sel) continuously, through the `mux`.
- If `ack`=1, go to IDLE and load `last` <= `sel`.
- If `ack`=0, stay in BUSY.

Rules that apply in every cycle:
- The grant is owned until `ack`. Deasserting `req[sel]` during BUSY does not release or change the grant. Requests arriving during BUSY wait.
- `ack` sampled in IDLE is ignored.
- Winner selection is described under Configuration.
- Reset values: state=IDLE, valid=0, grant=0, sel=0, last=N-1. `o` then shows b(0) because sel=0, but it is don't-care while valid=0.
- Reset asserted while BUSY drops `valid` and `grant` on the next edge. The pending grant is discarded with no ack needed. `req` and `ack` are ignored during reset.
- `sel` and `grant` change only on an IDLE->BUSY transition.
- Index arithmetic is modulo N; with CW bits the wrap from N-1 to 0 is natural.

## Timing

- Grant latency: `req` sampled high at edge t gives valid=1, sel and grant at t+1 (registered, one cycle).
- Release: `ack`=1 sampled at edge t gives valid=0 at t+1.
- Back-to-back grants always have exactly one IDLE cycle between them. A pending request gets its next grant at the earliest at t+2 after the ack edge.
- `o` is combinational from `i` and the registered `sel`: no added latency. Changes in b(sel) propagate within the same cycle.
- `ack` held high continuously gives the pattern grant, idle, grant, idle, and so on.

## Configuration

Macro **IRQ_ARBITER_RR_EN** selects the winner policy.
- **Defined (round-robin):** the winner is the first k with `req[k]`=1, searching `last+1`, `last+2`, ... modulo N. After reset the search starts at 0 because `last` resets to N-1. A continuously requesting requester therefore waits at most N-1 grants.
- **Undefined (fixed priority):** the winner is the lowest index k with `req[k]`=1. The `last` register is not built.

## Structure

- Shared package/header holds:
  - state encodings: IDLE=1'b0, BUSY=1'b1;
  - the reset value of `last` (N-1);
  - the function computing N from CW.
- Sub-modules:
  - `prio_enc`: combinational priority encoder (req, start index -> winner index, any). Fixed-priority mode calls it with start=0.
  - The existing `mux` is instantiated for the datapath, with DW and CW passed through. Its `s` port connects to `sel`.

## Test plan

All scenarios use DW=8 and CW=2, with i = {8'hA0, 8'hA1, 8'hA2, 8'hA3}.

1. **Reset:** hold rst for 2 cycles while req=4'b1111.
   - Expected: valid=0, grant=0, sel=0 during reset.
   - Expected: one cycle after release, valid=1 and sel=0, o=8'hA0.
2. **Single request and ack:** req=4'b0100.
   - Expected: the next cycle gives sel=2, grant=4'b0100, o=8'hA2.
   - Drop req and wait 5 cycles: the grant is still held.
   - ack=1: valid=0 one cycle later.
3. **Round-robin (macro defined):** req=4'b1111 constantly, ack=1 constantly.
   - Expected grant sequence: sel=0, 1, 2, 3, 0, with valid alternating 1/0.
4. **Fixed priority (macro undefined):** same stimulus as scenario 3.
   - Expected: sel=0 on every grant.
   - Then req=4'b1010: sel=1 on every grant.
5. **Simultaneous events:** in BUSY with sel=1, assert req[3] in the same cycle as ack.
   - Expected: one IDLE cycle, then sel=3.
   - Also: ack asserted in IDLE causes no state change.
6. **Reset mid-operation:** in BUSY with sel=2, assert rst for one cycle with ack=0.
   - Expected: valid=0 and grant=0 next cycle.
   - Expected after release with req=4'b0100: a fresh grant with sel=2.
